// File: rtl/led_share_sched.sv
// led_share_sched: time-slice scheduler sharing 8 user LEDs among N_REQ
// requesters. Round-robin arbitration, grant bounded to SLOT_TICKS prescaler
// ticks, one idle (gnt=0) fairness cycle between consecutive grants.
//
// Ports:
//   hwclk    in   1          sole clock, rising edge
//   rst      in   1          synchronous active-high reset
//   req      in   N_REQ      level requests, bit i = requester i
//   pattern  in   8*N_REQ    requester i pattern on [8i+7:8i]
//   led      out  8          LED drive (registered)
//   gnt      out  N_REQ      one-hot grant (registered), zero when idle
//   busy     out  1          high while a grant is active (registered)
//
// Optional feature macro: LED_SHARE_IDLE_COUNT_EN
//   defined   -> idle LEDs show the top 8 prescaler bits (heartbeat)
//   undefined -> idle LEDs are dark (8'h00)
module led_share_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned PRESCALE_W = 18,
  parameter int unsigned SLOT_TICKS = 4
) (
  input  logic                 hwclk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   pattern,
  output logic [7:0]           led,
  output logic [N_REQ-1:0]     gnt,
  output logic                 busy
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SLOT_W = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_TICKS - 1);
  localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(N_REQ - 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [PRESCALE_W-1:0] presc, presc_nxt;
  logic [SLOT_W-1:0]     slot, slot_nxt;
  logic [IDX_W-1:0]      last, last_nxt;
  logic [N_REQ-1:0]      gnt_nxt;
  logic                  busy_nxt;
  logic [7:0]            led_nxt;

  logic                  tick;
  logic                  any_req;
  logic [IDX_W-1:0]      winner;
  logic                  owner_req;
  logic [7:0]            owner_pat;
  logic [7:0]            idle_led;

  assign tick      = &presc;
  assign any_req   = |req;
  // Owner index is the last winner while in OWN.
  assign owner_req = req[last];
  assign owner_pat = pattern[int'(last)*8 +: 8];

  // Idle LED value.
`ifdef LED_SHARE_IDLE_COUNT_EN
  if (PRESCALE_W >= 8) begin : g_idle_wide
    assign idle_led = presc[PRESCALE_W-1 -: 8];
  end else begin : g_idle_narrow
    assign idle_led = 8'(presc);
  end
`else
  assign idle_led = 8'h00;
`endif

  // Round-robin search from last+1; scanning downward leaves the nearest hit.
  always_comb begin
    winner = '0;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      if (req[(int'(last) + i) % int'(N_REQ)]) begin
        winner = IDX_W'((int'(last) + i) % int'(N_REQ));
      end
    end
  end

  // State and output registers.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      slot  <= '0;
      last  <= LAST_RST;
      gnt   <= '0;
      busy  <= 1'b0;
      led   <= 8'h00;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      slot  <= slot_nxt;
      last  <= last_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      led   <= led_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc + PRESCALE_W'(1);
    slot_nxt  = slot;
    last_nxt  = last;
    gnt_nxt   = gnt;
    busy_nxt  = busy;
    led_nxt   = led;

    case (state)
      IDLE: begin
        led_nxt  = idle_led;
        slot_nxt = '0;
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (any_req) begin
          state_nxt = OWN;
          gnt_nxt   = N_REQ'(1) << winner;
          busy_nxt  = 1'b1;
          last_nxt  = winner;
        end
      end
      OWN: begin
        led_nxt = owner_pat;
        if (tick) slot_nxt = slot + SLOT_W'(1);
        // Release or slot expiry both hand back to IDLE for the fairness gap.
        if (!owner_req || (tick && (slot == SLOT_LAST))) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_led_share_sched.sv
// Bench for led_share_sched with N_REQ=4, PRESCALE_W=2, SLOT_TICKS=2, plus a
// second instance with PRESCALE_W=8 for the idle display.
module tb_led_share_sched;

  logic        hwclk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] pattern;
  logic [7:0]  led;
  logic [3:0]  gnt;
  logic        busy;

  logic        rst2;
  logic [3:0]  req2;
  logic [31:0] pattern2;
  logic [7:0]  led2;
  logic [3:0]  gnt2;
  logic        busy2;

  int total = 0;
  int bad   = 0;

`ifdef LED_SHARE_IDLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  led_share_sched #(.N_REQ(4), .PRESCALE_W(2), .SLOT_TICKS(2)) dut (
    .hwclk(hwclk), .rst(rst), .req(req), .pattern(pattern),
    .led(led), .gnt(gnt), .busy(busy)
  );

  led_share_sched #(.N_REQ(4), .PRESCALE_W(8), .SLOT_TICKS(2)) dut_cnt (
    .hwclk(hwclk), .rst(rst2), .req(req2), .pattern(pattern2),
    .led(led2), .gnt(gnt2), .busy(busy2)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    int          n;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  led;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic [7:0] led;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input logic r, input logic [3:0] rq, input int n,
                     input logic [3:0] eg, input logic eb, input logic [7:0] el);
    vec_t v;
    v.rst = r; v.req = rq; v.n = n; v.gnt = eg; v.busy = eb; v.led = el;
    vecs.push_back(v);
  endtask

  // Drive one cycle, queue the expectation, compare after the edge.
  task automatic cycle(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                       input logic eb, input logic [7:0] el, input string tag);
    exp_t e;
    exp_t p;
    rst = r;
    req = rq;
    e.gnt = eg; e.busy = eb; e.led = el; e.tag = tag;
    sb.push_back(e);
    @(posedge hwclk);
    #1;
    p = sb.pop_front();
    total++;
    if (gnt !== p.gnt) begin
      bad++;
      $display("FAIL %s gnt got=%b want=%b", p.tag, gnt, p.gnt);
    end
    total++;
    if (busy !== p.busy) begin
      bad++;
      $display("FAIL %s busy got=%b want=%b", p.tag, busy, p.busy);
    end
    total++;
    if (led !== p.led) begin
      bad++;
      $display("FAIL %s led got=%h want=%h", p.tag, led, p.led);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'hF;
    pattern  = {8'h44, 8'hA5, 8'h22, 8'h11};
    rst2     = 1'b1;
    req2     = 4'h0;
    pattern2 = 32'h0;

    // Reset held 3 cycles with all requests up.
    add(1'b1, 4'hF, 3, 4'h0, 1'b0, 8'h00);
    // Round robin; each grant lasts 7 cycles at this prescaler phase.
    add(1'b0, 4'hF, 1, 4'h1, 1'b1, 8'h00);
    add(1'b0, 4'hF, 6, 4'h1, 1'b1, 8'h11);
    add(1'b0, 4'hF, 1, 4'h0, 1'b0, 8'h11);
    add(1'b0, 4'hF, 1, 4'h2, 1'b1, 8'h00);
    add(1'b0, 4'hF, 6, 4'h2, 1'b1, 8'h22);
    add(1'b0, 4'hF, 1, 4'h0, 1'b0, 8'h22);
    add(1'b0, 4'hF, 1, 4'h4, 1'b1, 8'h00);
    add(1'b0, 4'hF, 6, 4'h4, 1'b1, 8'hA5);
    add(1'b0, 4'hF, 1, 4'h0, 1'b0, 8'hA5);
    add(1'b0, 4'hF, 1, 4'h8, 1'b1, 8'h00);
    add(1'b0, 4'hF, 6, 4'h8, 1'b1, 8'h44);
    add(1'b0, 4'hF, 1, 4'h0, 1'b0, 8'h44);
    add(1'b0, 4'hF, 1, 4'h1, 1'b1, 8'h00);
    // Reset mid-slot.
    add(1'b1, 4'hF, 1, 4'h0, 1'b0, 8'h00);
    // Single requester 2: grant, expiry, gap, re-grant.
    add(1'b0, 4'h4, 1, 4'h4, 1'b1, 8'h00);
    add(1'b0, 4'h4, 6, 4'h4, 1'b1, 8'hA5);
    add(1'b0, 4'h4, 1, 4'h0, 1'b0, 8'hA5);
    add(1'b0, 4'h4, 1, 4'h4, 1'b1, 8'h00);
    // Requester 2 releases, requester 1 wins, then releases with 3 pending.
    add(1'b0, 4'h2, 1, 4'h0, 1'b0, 8'hA5);
    add(1'b0, 4'h2, 1, 4'h2, 1'b1, 8'h00);
    add(1'b0, 4'hA, 1, 4'h2, 1'b1, 8'h22);
    add(1'b0, 4'h8, 1, 4'h0, 1'b0, 8'h22);
    add(1'b0, 4'h8, 1, 4'h8, 1'b1, 8'h00);
    add(1'b0, 4'h0, 1, 4'h0, 1'b0, 8'h44);
    add(1'b0, 4'h0, 2, 4'h0, 1'b0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        cycle(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].busy, vecs[i].led,
              $sformatf("row%0d.%0d", i, j));
      end
    end

    // Live pattern change while requester 0 owns.
    pattern[7:0] = 8'h0F;
    cycle(1'b0, 4'h1, 4'h1, 1'b1, 8'h00, "live_grant");
    cycle(1'b0, 4'h1, 4'h1, 1'b1, 8'h0F, "live_0f");
    pattern[7:0] = 8'hF0;
    cycle(1'b0, 4'h1, 4'h1, 1'b1, 8'hF0, "live_f0");

    // Reset during OWN, then quiet idle.
    cycle(1'b1, 4'h1, 4'h0, 1'b0, 8'h00, "own_rst");
    cycle(1'b0, 4'h0, 4'h0, 1'b0, 8'h00, "post_rst");

    // Idle display on the 8-bit prescaler instance: prescaler delayed 1 cycle.
    rst2 = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      logic [7:0] want;
      @(posedge hwclk);
      #1;
      want = CNT_EN ? 8'(j - 1) : 8'h00;
      total++;
      if (led2 !== want) begin
        bad++;
        $display("FAIL idle_led%0d led got=%h want=%h", j, led2, want);
      end
      total++;
      if (gnt2 !== 4'h0) begin
        bad++;
        $display("FAIL idle_gnt%0d gnt got=%b want=0000", j, gnt2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_share_sched.md
# led_share_sched

Time-slice scheduler that shares the board's 8 user LEDs among `N_REQ` requesters. It sits between the top-level LED pins and the blocks that want to display status patterns. It arbitrates round-robin and grants ownership for a bounded slot measured in prescaler ticks. While no requester owns the LEDs, it drives an idle pattern.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `PRESCALE_W`, 18: prescaler width; one tick every 2^`PRESCALE_W` cycles.
- `SLOT_TICKS`, 4: maximum ticks per grant (>=1).

Ports:
- `hwclk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, synchronous to `hwclk`, active-high.
- `req`  in  `N_REQ`: level request, bit i = requester i.
- `pattern`  in  8*`N_REQ`: requester i pattern on bits [8i+7:8i].
- `led`  out  8: LED drive, registered.
- `gnt`  out  `N_REQ`: one-hot grant, registered; all-zero when idle.
- `busy`  out  1: high while any grant is active.

## Operation
- Prescaler: free-running `PRESCALE_W`-bit up-counter that wraps. `tick` is an internal one-cycle pulse when the prescaler is all ones. The prescaler never stops or restarts except on `rst`.
- FSM with two states, IDLE and OWN.
- IDLE:
  - If any `req` bit is set, pick the winner round-robin, searching from `last+1` upward modulo `N_REQ`.
  - Next cycle: state OWN, `gnt` = one-hot(winner), `last` <= winner, slot counter <= 0.
  - If no `req` bit is set, stay in IDLE.
- OWN:
  - `led` <= pattern slice of the owner every cycle, so a live pattern change shows 1 cycle later.
  - The slot counter increments on each `tick`.
  - Release: if `req[owner]` = 0, next cycle is IDLE.
  - Expiry: if `tick` occurs while the slot counter = `SLOT_TICKS`-1, next cycle is IDLE.
  - Release and expiry in the same cycle have the same result: IDLE next cycle.
- Every return to IDLE gives exactly one cycle with `gnt`=0 before the next grant. That cycle is a fairness gap; the new arbitration happens in it.
- Fairness: a requester that keeps `req` high is re-granted only after every other pending requester has been served once.
- `busy` = (state == OWN), registered together with `gnt`.
- `led` in IDLE: see Configuration.
- Reset values: state IDLE, `gnt`=0, `busy`=0, `led`=8'h00, prescaler=0, slot counter=0, `last`=`N_REQ`-1, so requester 0 has first priority after reset.

## Timing
- Request to grant: 1 cycle. `req` is sampled in IDLE at edge k, and `gnt` and `busy` are high after edge k+1.
- Grant to LED: `led` shows the owner pattern from edge k+2. During cycle k+1, `led` still holds the idle value.
- Slot length: the grant lasts between (`SLOT_TICKS`-1)*2^`PRESCALE_W`+1 and `SLOT_TICKS`*2^`PRESCALE_W` cycles. The exact length depends on prescaler phase at grant.
- Release latency: `req[owner]` falling at edge k makes `gnt` and `busy` low after edge k+1.
- Requests that arrive mid-slot are queued implicitly by the level `req` and are not lost.
- `rst` high at edge k overrides everything, including mid-slot: all outputs equal their reset values after edge k.

## Configuration
- `LED_SHARE_IDLE_COUNT_EN`
  - Defined: in IDLE, `led` <= prescaler[`PRESCALE_W`-1 -: 8], giving a heartbeat counter display. If `PRESCALE_W`<8, the missing upper bits are zero.
  - Undefined: in IDLE, `led` <= 8'h00.
- The macro has no effect on arbitration or timing.

## Test plan
Bench parameters: `N_REQ`=4, `PRESCALE_W`=2, `SLOT_TICKS`=2.
- Reset check: hold `rst` 3 cycles with `req`=4'hF. Required: `gnt`=0, `busy`=0, `led`=00 every cycle. First grant after release is `gnt`=4'b0001.
- Single requester: `req`=4'b0100 with pattern2=8'hA5. Required: `gnt`=4'b0100 one cycle after sampling and `led`=A5 one cycle later. The grant ends within 5..8 cycles, followed by one cycle of `gnt`=0, then it is re-granted.
- Round-robin: `req`=4'hF held. Required grant order 0001, 0010, 0100, 1000, 0001, with exactly one idle cycle between consecutive grants.
- Early release: requester 1 owns the LEDs and drops `req[1]` at edge k. Required: `gnt`=0 after edge k+1, and requester 3 (pending) is granted after edge k+2.
- Live pattern change: while requester 0 owns, pattern0 changes 8'h0F to 8'hF0 at edge k. Required: `led`=F0 after edge k+1, with no grant change.
- Mid-slot reset and idle display: assert `rst` during OWN. Required: all outputs equal their reset values after that edge. With `LED_SHARE_IDLE_COUNT_EN` defined and `PRESCALE_W`=8, `led` in IDLE equals the prescaler value 1 cycle delayed.
